// File: rtl/clm_inv_chain_pkg.sv
// -----------------------------------------------------------------------------
// clm_inv_chain_pkg
// Shared types for the masked GF(2^8) inversion controller:
//   state_t      masked byte, one 8-bit share per masking share
//   base_poly_t  9-bit reduction polynomial (e.g. 0x11B)
//   inv_src_e    operand register selector of an addition-chain step
//   inv_dst_e    destination register selector of an addition-chain step
//   inv_step_t   one step-table entry {src1, src2, dst}
//   inv_state_e  controller FSM states
// -----------------------------------------------------------------------------
package clm_inv_chain_pkg;

  localparam int MASK_ORDER = 1;
  localparam int NUM_SHARES = MASK_ORDER + 1;

  typedef logic [NUM_SHARES-1:0][7:0] state_t;
  typedef logic [8:0]                 base_poly_t;

  localparam int INV_STEPS = 11;
  typedef logic [3:0] step_t;
  localparam step_t LAST_STEP = step_t'(INV_STEPS - 1);

  typedef enum logic [2:0] {
    SRC_X,
    SRC_X2,
    SRC_X3,
    SRC_X12,
    SRC_ACC
  } inv_src_e;

  typedef enum logic [2:0] {
    DST_X2,
    DST_X3,
    DST_ACC,
    DST_ACC_X12,
    DST_OUT
  } inv_dst_e;

  typedef struct packed {
    inv_src_e src1;
    inv_src_e src2;
    inv_dst_e dst;
  } inv_step_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } inv_state_e;

  // Operand routing: pick one of the chain registers by selector.
  function automatic state_t inv_pick(input inv_src_e src, input state_t x,
                                      input state_t x2, input state_t x3,
                                      input state_t x12, input state_t acc);
    state_t r;
    case (src)
      SRC_X:   r = x;
      SRC_X2:  r = x2;
      SRC_X3:  r = x3;
      SRC_X12: r = x12;
      default: r = acc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clm_inv_chain_if.sv
// -----------------------------------------------------------------------------
// clm_inv_chain_if
// Link between the inversion controller and the serial masked multiplier.
//   mul_p1, mul_p2  masked operands            (controller -> multiplier)
//   mul_P           reduction polynomial       (controller -> multiplier)
//   mul_drdy_i      one-cycle issue pulse      (controller -> multiplier)
//   mul_drdy_o      product strobe             (multiplier -> controller)
//   mul_out         masked product             (multiplier -> controller)
// Modports: master = controller side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface clm_inv_chain_if;

  clm_inv_chain_pkg::state_t     mul_p1;
  clm_inv_chain_pkg::state_t     mul_p2;
  clm_inv_chain_pkg::base_poly_t mul_P;
  logic                          mul_drdy_i;
  logic                          mul_drdy_o;
  clm_inv_chain_pkg::state_t     mul_out;

  modport master (
    output mul_p1, mul_p2, mul_P, mul_drdy_i,
    input  mul_drdy_o, mul_out
  );

  modport slave (
    input  mul_p1, mul_p2, mul_P, mul_drdy_i,
    output mul_drdy_o, mul_out
  );

endinterface

// File: rtl/clm_inv_chain_step_rom.sv
// -----------------------------------------------------------------------------
// clm_inv_step_rom
// Combinational addition-chain table for x^254 (GF(2^8) inverse).
//   step_i   step index 0..10
//   entry_o  {src1, src2, dst} for that step
// Swapping this table retargets the controller to another exponent.
// -----------------------------------------------------------------------------
module clm_inv_step_rom
  import clm_inv_chain_pkg::*;
(
  input  step_t     step_i,
  output inv_step_t entry_o
);

  always_comb begin
    case (step_i)
      4'd0:    entry_o = '{SRC_X,   SRC_X,   DST_X2};      // x^2
      4'd1:    entry_o = '{SRC_X2,  SRC_X,   DST_X3};      // x^3
      4'd2:    entry_o = '{SRC_X3,  SRC_X3,  DST_ACC};     // x^6
      4'd3:    entry_o = '{SRC_ACC, SRC_ACC, DST_ACC_X12}; // x^12
      4'd4:    entry_o = '{SRC_ACC, SRC_X3,  DST_ACC};     // x^15
      4'd5,
      4'd6,
      4'd7,
      4'd8:    entry_o = '{SRC_ACC, SRC_ACC, DST_ACC};     // x^30..x^240
      4'd9:    entry_o = '{SRC_ACC, SRC_X12, DST_ACC};     // x^252
      4'd10:   entry_o = '{SRC_ACC, SRC_X2,  DST_OUT};     // x^254
      default: entry_o = '{SRC_X,   SRC_X,   DST_OUT};     // never issued
    endcase
  end

endmodule

// File: rtl/clm_inv_chain.sv
// -----------------------------------------------------------------------------
// clm_inv_chain
// Masked GF(2^8) inversion (a^254, 0 -> 0) by driving an external serial
// masked multiplier through an 11-step addition chain. Shares are only routed
// between registers here; all arithmetic lives in the multiplier.
//   clk, rst    clock, synchronous active-high reset
//   drdy_i      start strobe, samples a and P (ignored while busy / in DONE)
//   a, P        masked operand, reduction polynomial
//   busy        high from the accepted start until drdy_o
//   drdy_o      one-cycle result pulse, out valid in the same cycle
//   out         masked a^254, held until the next drdy_o
//   mul         multiplier link (master modport)
// Optional macro CLM_INV_TIMEOUT_EN: adds parameter MAX_WAIT and sticky err
// output; a WAIT longer than MAX_WAIT cycles aborts to IDLE without drdy_o.
// -----------------------------------------------------------------------------
module clm_inv_chain
  import clm_inv_chain_pkg::*;
#(
  parameter int d = MASK_ORDER
`ifdef CLM_INV_TIMEOUT_EN
  ,
  parameter int MAX_WAIT = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drdy_i,
  input  state_t                a,
  input  base_poly_t            P,
  output logic                  busy,
  output logic                  drdy_o,
  output state_t                out,
`ifdef CLM_INV_TIMEOUT_EN
  output logic                  err,
`endif
  clm_inv_chain_if.master       mul
);

  // The share count is fixed by the types package; d must agree with it.
  if (d != MASK_ORDER) begin : g_d_mismatch
    $error("clm_inv_chain: d does not match clm_inv_chain_pkg::MASK_ORDER");
  end

  inv_state_e state_q;
  step_t      step_q;
  step_t      step_nxt;
  inv_dst_e   dst_q;

  state_t     x_q,   x_d;
  state_t     x2_q,  x2_d;
  state_t     x3_q,  x3_d;
  state_t     x12_q, x12_d;
  state_t     acc_q, acc_d;
  state_t     out_q, out_d;

  state_t     p1_q, p2_q;
  state_t     p1_nxt, p2_nxt;
  base_poly_t mul_P_q;
  logic       busy_q, drdy_o_q, mul_drdy_i_q;
  logic       accept;
  logic       wb_en;
  inv_step_t  entry;

`ifdef CLM_INV_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;
  assign err = err_q;
`endif

  assign accept = (state_q == ST_IDLE) && drdy_i;
  assign wb_en  = (state_q == ST_WAIT) && mul.mul_drdy_o;

  // Next step to issue: 0 on a start, step+1 after a write-back.
  assign step_nxt = (state_q == ST_WAIT) ? step_t'(step_q + 4'd1) : '0;

  clm_inv_step_rom u_rom (
    .step_i  (step_nxt),
    .entry_o (entry)
  );

  // Register-file write-back. The operand mux below reads the _d values so
  // that a product written this cycle can be issued in the very next ISSUE.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    x_d   = x_q;
    x2_d  = x2_q;
    x3_d  = x3_q;
    x12_d = x12_q;
    acc_d = acc_q;
    out_d = out_q;
    if (accept) x_d = a;
    if (wb_en) begin
      case (dst_q)
        DST_X2:      x2_d = mul.mul_out;
        DST_X3:      x3_d = mul.mul_out;
        DST_ACC:     acc_d = mul.mul_out;
        DST_ACC_X12: begin
          acc_d = mul.mul_out;
          x12_d = mul.mul_out;
        end
        default:     out_d = mul.mul_out;
      endcase
    end
  end

  assign p1_nxt = inv_pick(entry.src1, x_d, x2_d, x3_d, x12_d, acc_d);
  assign p2_nxt = inv_pick(entry.src2, x_d, x2_d, x3_d, x12_d, acc_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the chain registers are reset too: an abort must not leave a
      // previous operand's shares visible on out or the multiplier operands.
      state_q      <= ST_IDLE;
      step_q       <= '0;
      dst_q        <= DST_X2;
      x_q          <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      x12_q        <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      mul_P_q      <= '0;
      busy_q       <= 1'b0;
      drdy_o_q     <= 1'b0;
      mul_drdy_i_q <= 1'b0;
`ifdef CLM_INV_TIMEOUT_EN
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every register here sees the
      // pre-edge value of every other register regardless of statement order.
      mul_drdy_i_q <= 1'b0;
      drdy_o_q     <= 1'b0;
      x_q          <= x_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      x12_q        <= x12_d;
      acc_q        <= acc_d;
      out_q        <= out_d;

      case (state_q)
        ST_IDLE: begin
          if (drdy_i) begin
            mul_P_q      <= P;
            step_q       <= '0;
            p1_q         <= p1_nxt;
            p2_q         <= p2_nxt;
            dst_q        <= entry.dst;
            mul_drdy_i_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end

        // Issue pulse is already on the link; just move on. A product strobe
        // seen here belongs to no outstanding request and is dropped.
        ST_ISSUE: begin
`ifdef CLM_INV_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mul.mul_drdy_o) begin
            if (step_q < LAST_STEP) begin
              step_q       <= step_nxt;
              p1_q         <= p1_nxt;
              p2_q         <= p2_nxt;
              dst_q        <= entry.dst;
              mul_drdy_i_q <= 1'b1;
              state_q      <= ST_ISSUE;
            end else begin
              state_q <= ST_DONE;
            end
          end
`ifdef CLM_INV_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end

        // out was written on the last write-back; announce it next cycle.
        ST_DONE: begin
          drdy_o_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign drdy_o         = drdy_o_q;
  assign out            = out_q;
  assign mul.mul_p1     = p1_q;
  assign mul.mul_p2     = p2_q;
  assign mul.mul_P      = mul_P_q;
  assign mul.mul_drdy_i = mul_drdy_i_q;

endmodule

// File: tb/tb_clm_inv_chain.sv
// -----------------------------------------------------------------------------
// tb_clm_inv_chain
// Bench for clm_inv_chain with a behavioural masked multiplier of adjustable
// latency. Expected inverses are queued at each start and popped at drdy_o.
// Define CLM_INV_TIMEOUT_EN to also exercise the stall timeout (MAX_WAIT=8).
// -----------------------------------------------------------------------------
module tb_clm_inv_chain;
  import clm_inv_chain_pkg::*;

  localparam base_poly_t POLY = 9'h11B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drdy_i = 1'b0;
  state_t     a = '0;
  base_poly_t P = '0;
  logic       busy;
  logic       drdy_o;
  state_t     out;
`ifdef CLM_INV_TIMEOUT_EN
  logic       err;
`endif

  clm_inv_chain_if mul_if ();

`ifdef CLM_INV_TIMEOUT_EN
  clm_inv_chain #(.d(1), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .drdy_i(drdy_i), .a(a), .P(P),
    .busy(busy), .drdy_o(drdy_o), .out(out), .err(err), .mul(mul_if)
  );
`else
  clm_inv_chain #(.d(1)) dut (
    .clk(clk), .rst(rst), .drdy_i(drdy_i), .a(a), .P(P),
    .busy(busy), .drdy_o(drdy_o), .out(out), .mul(mul_if)
  );
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int issue_base = 0;
  int drdy_o_cnt = 0;
  int issue_cnt = 0;
  int lat = 3;
  bit stall = 1'b0;
  logic [7:0] sb[$];
  logic [7:0] inv_ref[256];

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y,
                                        input base_poly_t poly);
    logic [7:0] r = '0;
    logic [7:0] xx = x;
    for (int i = 0; i < 8; i++) begin
      logic carry;
      if (y[i]) r ^= xx;
      carry = xx[7];
      xx = xx << 1;
      if (carry) xx ^= poly[7:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] recomb(input state_t s);
    return s[0] ^ s[1];
  endfunction

  function automatic state_t mask(input logic [7:0] v);
    logic [7:0] r = 8'($urandom);
    state_t s;
    s[0] = r;
    s[1] = v ^ r;
    return s;
  endfunction

  // ---------------- behavioural masked multiplier ----------------
  int m_cnt = 0;
  logic [7:0] m_val = '0;

  always @(posedge clk) begin
    mul_if.mul_drdy_o <= 1'b0;
    if (rst) begin
      m_cnt <= 0;
    end else if (mul_if.mul_drdy_i) begin
      if (lat == 1 && !stall) begin
        mul_if.mul_drdy_o <= 1'b1;
        mul_if.mul_out    <= mask(gf_mul(recomb(mul_if.mul_p1), recomb(mul_if.mul_p2), mul_if.mul_P));
      end else begin
        m_val <= gf_mul(recomb(mul_if.mul_p1), recomb(mul_if.mul_p2), mul_if.mul_P);
        m_cnt <= (lat == 1) ? 1 : lat - 1;
      end
    end else if (m_cnt != 0 && !stall) begin
      if (m_cnt == 1) begin
        mul_if.mul_drdy_o <= 1'b1;
        mul_if.mul_out    <= mask(m_val);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (drdy_o) drdy_o_cnt <= drdy_o_cnt + 1;
    if (mul_if.mul_drdy_i) issue_cnt <= issue_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] v, input logic [7:0] exp, input bit accepted);
    @(negedge clk);
    a      = mask(v);
    P      = POLY;
    drdy_i = 1'b1;
    if (accepted) begin
      sb.push_back(exp);
      start_cyc  = cyc + 1;
      issue_base = issue_cnt;
    end
    @(negedge clk);
    drdy_i = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    bit seen = 1'b0;
    int budget = 11 * (lat + 1) + 20;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (drdy_o) seen = 1'b1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      check(tag, 32'(recomb(out)), 32'(sb.pop_front()));
      check({tag, "_lat"}, 32'(cyc - start_cyc), 32'(11 * (lat + 1) + 1));
      check({tag, "_busy"}, 32'(busy), 32'd0);
    end else if (sb.size() != 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   32'(busy),              32'd0);
    check({tag, "_drdy_o"}, 32'(drdy_o),            32'd0);
    check({tag, "_out"},    32'(out),               32'd0);
    check({tag, "_p1"},     32'(mul_if.mul_p1),     32'd0);
    check({tag, "_p2"},     32'(mul_if.mul_p2),     32'd0);
    check({tag, "_P"},      32'(mul_if.mul_P),      32'd0);
    check({tag, "_issue"},  32'(mul_if.mul_drdy_i), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt0;

    // Reference inverse table by exhaustive search.
    inv_ref[0] = 8'h00;
    for (int x = 1; x < 256; x++)
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y), POLY) == 8'h01) inv_ref[x] = 8'(y);

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Directed values at L=3.
    lat = 3;
    start(8'h53, 8'hCA, 1'b1);
    wait_result("inv_53");
    check("issue_pulses", 32'(issue_cnt - issue_base), 32'd11);
    check("mul_P_latched", 32'(mul_if.mul_P), 32'(POLY));
    start(8'h01, 8'h01, 1'b1);
    wait_result("inv_01");
    start(8'h00, 8'h00, 1'b1);
    wait_result("inv_00");

    // A second start during a busy run is ignored.
    start(8'h53, 8'hCA, 1'b1);
    repeat (7) @(negedge clk);
    start(8'h02, 8'h00, 1'b0);
    wait_result("ignored_start");

    // Abort by reset mid-run: outputs clear, no result appears.
    start(8'h53, 8'hCA, 1'b1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("abort");
    sb.delete();
    cnt0 = drdy_o_cnt;
    repeat (60) @(negedge clk);
    check("abort_no_drdy", 32'(drdy_o_cnt - cnt0), 32'd0);
    start(8'h53, 8'hCA, 1'b1);
    wait_result("after_abort");

    // Full sweep at the two latency corners.
    foreach (inv_ref[v]) begin
      lat = 1;
      start(8'(v), inv_ref[v], 1'b1);
      wait_result($sformatf("sweep_l1_%02h", v));
    end
    foreach (inv_ref[v]) begin
      lat = 5;
      start(8'(v), inv_ref[v], 1'b1);
      wait_result($sformatf("sweep_l5_%02h", v));
    end

`ifdef CLM_INV_TIMEOUT_EN
    begin
      bit seen = 1'b0;
      lat   = 3;
      stall = 1'b1;
      cnt0  = drdy_o_cnt;
      start(8'h53, 8'h00, 1'b0);
      start_cyc = cyc;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (err) seen = 1'b1;
        else @(negedge clk);
      end
      check("timeout_err", 32'(seen), 32'd1);
      check("timeout_lat", 32'(cyc - start_cyc), 32'd9);
      check("timeout_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      check("timeout_no_drdy", 32'(drdy_o_cnt - cnt0), 32'd0);
      check("timeout_sticky", 32'(err), 32'd1);
      stall = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      check("timeout_clear", 32'(err), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
